// File: rtl/ring_window_pkg.sv
// Shared pointer type, pointer field helpers and the retire-count width for the ring window tracker.
package ring_window_pkg;

    localparam int PKG_LOG_DEPTH  = 3;
    localparam int PKG_RETIRE_MAX = 2;

    // Index bits plus one wrap bit so that head==tail can be told apart from a full window
    typedef logic [PKG_LOG_DEPTH:0] ptr_t;

    function automatic logic [PKG_LOG_DEPTH-1:0] ptrIdx(input ptr_t p);
        return p[PKG_LOG_DEPTH-1:0];
    endfunction

    function automatic logic ptrWrap(input ptr_t p);
        return p[PKG_LOG_DEPTH];
    endfunction

    function automatic int cwOf(input int retire_max);
        return $clog2(retire_max + 1);
    endfunction

endpackage

// File: rtl/ring_span_mask.sv
// Circular span mask: bit i set when index i lies in [head, tail) around the ring, or everywhere when full.
module ring_span_mask
    import ring_window_pkg::*;
#(
    parameter int  LOG_DEPTH = PKG_LOG_DEPTH,
    localparam int DEPTH     = 1 << LOG_DEPTH
) (
    input  logic [LOG_DEPTH-1:0] i_head_idx,
    input  logic [LOG_DEPTH-1:0] i_tail_idx,
    input  logic                 i_full,
    output logic [0:DEPTH-1]     o_mask
);

    always_comb begin
        o_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_full) begin
                o_mask[i] = 1'b1;
            end else if (i_head_idx <= i_tail_idx) begin
                o_mask[i] = (LOG_DEPTH'(i) >= i_head_idx) && (LOG_DEPTH'(i) < i_tail_idx);
            end else begin
                o_mask[i] = (LOG_DEPTH'(i) >= i_head_idx) || (LOG_DEPTH'(i) < i_tail_idx);
            end
        end
    end

endmodule

// File: rtl/ring_window_tracker.sv
// In-order window over a circular buffer: alloc at tail, out-of-order done, in-order retire of up to
// RETIRE_MAX entries per cycle from head. All status outputs come from registered state only.
module ring_window_tracker
    import ring_window_pkg::*;
#(
    parameter int  LOG_DEPTH  = PKG_LOG_DEPTH,
    parameter int  RETIRE_MAX = PKG_RETIRE_MAX,
    localparam int DEPTH      = 1 << LOG_DEPTH,
    localparam int CW         = cwOf(RETIRE_MAX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 allocReq,
    output logic                 allocReady,
    output logic [LOG_DEPTH-1:0] allocIdx,
    input  logic                 doneValid,
    input  logic [LOG_DEPTH-1:0] doneIdx,
    output logic                 retireValid,
    output logic [LOG_DEPTH-1:0] retireIdx,
    output logic [CW-1:0]        retireCount,
    output logic [LOG_DEPTH-1:0] headIdx,
    output logic [LOG_DEPTH-1:0] tailIdx,
    output logic [0:DEPTH-1]     occMask,
    output logic [0:DEPTH-1]     doneMask,
    output logic [LOG_DEPTH:0]   count,
    output logic                 empty,
    output logic                 full,
    output logic                 errDone
);

    localparam int CNTW = LOG_DEPTH + 1;

    ptr_t                 r_head;
    ptr_t                 r_tail;
    logic [DEPTH-1:0]     r_done;
    logic                 r_err;

    logic [LOG_DEPTH-1:0] w_head_idx;
    logic [LOG_DEPTH-1:0] w_tail_idx;
    logic                 w_full;
    logic [CNTW-1:0]      w_count;
    logic                 w_alloc;
    logic                 w_done_ok;
    logic [CW-1:0]        w_k;
    logic                 w_run;
    logic [DEPTH-1:0]     w_done_nxt;

    assign w_head_idx = ptrIdx(r_head);
    assign w_tail_idx = ptrIdx(r_tail);
    assign w_full     = (w_head_idx == w_tail_idx) && (ptrWrap(r_head) != ptrWrap(r_tail));
    assign w_count    = r_tail - r_head;

    ring_span_mask #(
        .LOG_DEPTH (LOG_DEPTH)
    ) u_occ_mask (
        .i_head_idx (w_head_idx),
        .i_tail_idx (w_tail_idx),
        .i_full     (w_full),
        .o_mask     (occMask)
    );

    always_comb begin
        doneMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            doneMask[i] = occMask[i] & r_done[i];
        end
    end

    // Run of completed entries from head; the first gap stops the scan
    always_comb begin
        w_k   = '0;
        w_run = 1'b1;
        for (int j = 0; j < RETIRE_MAX; j++) begin
            if (w_run && (CNTW'(j) < w_count) && doneMask[w_head_idx + LOG_DEPTH'(j)]) begin
                w_k = CW'(j + 1);
            end else begin
                w_run = 1'b0;
            end
        end
    end

    // Judged on registered state, so an entry allocated this cycle is not yet a legal done target
    assign w_done_ok = doneValid && occMask[doneIdx] && !r_done[doneIdx];
    assign w_alloc   = allocReq && !w_full;

    always_comb begin
        w_done_nxt = r_done;
        for (int j = 0; j < RETIRE_MAX; j++) begin
            if (CW'(j) < w_k) begin
                w_done_nxt[w_head_idx + LOG_DEPTH'(j)] = 1'b0;
            end
        end
        if (w_done_ok) begin
            w_done_nxt[doneIdx] = 1'b1;
        end
        if (w_alloc) begin
            w_done_nxt[w_tail_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_done <= '0;
            r_err  <= 1'b0;
        end else begin
            r_head <= r_head + ptr_t'(w_k);
            r_tail <= r_tail + ptr_t'(w_alloc);
            r_done <= w_done_nxt;
            r_err  <= doneValid && !w_done_ok;
        end
    end

    assign allocReady  = !w_full;
    assign allocIdx    = w_tail_idx;
    assign retireValid = (w_k != '0);
    assign retireIdx   = w_head_idx;
    assign retireCount = w_k;
    assign headIdx     = w_head_idx;
    assign tailIdx     = w_tail_idx;
    assign count       = w_count;
    assign empty       = (r_head == r_tail);
    assign full        = w_full;
    assign errDone     = r_err;

endmodule

// File: doc/ring_window_tracker.md
# ring_window_tracker

Tracks an in-order window of DEPTH outstanding entries in a circular buffer. Entries are allocated at the tail, marked complete out of order, and retired in order from the head, up to RETIRE_MAX per cycle. It sits beside the prefetcher's request queues and supplies the per-entry occupancy and completion masks the queues index with. Unlike a bare head/tail mask generator, it owns the pointers and separates the empty and full cases.

## Interface

- LOG_DEPTH, 3: log2 of entry count; DEPTH = 1<<LOG_DEPTH (derived, not overridable).
- RETIRE_MAX, 2: maximum entries retired per cycle; 1 ≤ RETIRE_MAX ≤ DEPTH.
- CW (derived) = $clog2(RETIRE_MAX+1).

Ports:

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- allocReq  in  1  allocate one entry at the tail.
- allocReady  out  1  equals !full.
- allocIdx  out  LOG_DEPTH  index the next allocation takes (tail index).
- doneValid  in  1  mark entry doneIdx complete.
- doneIdx  in  LOG_DEPTH  entry being completed.
- retireValid  out  1  retireCount != 0.
- retireIdx  out  LOG_DEPTH  first retiring entry (head index).
- retireCount  out  CW  entries retiring at the coming edge.
- headIdx, tailIdx  out  LOG_DEPTH  pointer indices.
- occMask  out  [0:DEPTH-1]  bit i set if entry i is occupied.
- doneMask  out  [0:DEPTH-1]  bit i set if entry i is occupied and complete.
- count  out  LOG_DEPTH+1  occupied entries, 0..DEPTH.
- empty, full  out  1  window state.
- errDone  out  1  one-cycle pulse for an illegal done.

## Operation

- State:
  - headPtr and tailPtr are LOG_DEPTH+1 bits each; the MSB is a wrap bit.
  - doneBits holds DEPTH bits.
- Flags:
  - empty = (headPtr == tailPtr).
  - full = equal indices with different wrap bits.
  - count = tailPtr − headPtr, computed modulo 2^(LOG_DEPTH+1).
- occMask covers indices head through tail−1, circularly.
  - All zeros when empty; all ones when full. head==tail is never ambiguous.
- Allocation:
  - Accepted when allocReq && allocReady.
  - tailPtr increments and doneBits[tailIdx] is cleared.
  - allocReq while full is ignored; no state change and no error.
- Retirement:
  - k = number of consecutive set bits of doneMask starting at headIdx, wrapping, capped at RETIRE_MAX and at count.
  - At the edge, headPtr += k and those k doneBits clear.
- Done:
  - Legal only if the entry is occupied and not already done, judged on the registered state.
  - If legal, doneBits[doneIdx] is set at the edge.
  - If illegal, no state change and errDone=1 in the next cycle.
- Simultaneous events in one cycle:
  - Alloc, done and retire can all occur; they use disjoint entries by construction.
  - count' = count + alloc − k.
  - A done to an entry allocated in the same cycle is illegal, because that entry is not yet occupied.
- Reset: headPtr=tailPtr=0, doneBits=0, errDone=0. Reset takes priority over all inputs, including mid-operation; in-flight entries are discarded.

## Timing

- All status outputs are combinational from registered state only: allocReady, allocIdx, retire*, head/tailIdx, masks, count, empty, full. No input-to-output combinational path.
- Retirement of a newly completed entry:
  - The done bit is visible one cycle after doneValid.
  - The entry retires at the edge ending that cycle.
  - Minimum alloc→retire is 2 cycles: alloc in cycle n, done in n+1, retireValid in n+2.
- A slot freed by retirement becomes allocatable in the following cycle; there is no same-cycle bypass.
- errDone is registered: high exactly one cycle, the cycle after the offending doneValid.
- Reset values:
  - allocReady=1, empty=1, full=0, count=0.
  - occMask=0, doneMask=0, retireValid=0, retireCount=0, errDone=0.
  - headIdx=tailIdx=allocIdx=retireIdx=0.

## Structure

- Shared package, ring_window_pkg, holds:
  - the pointer typedef (LOG_DEPTH+1 bits);
  - the ptrIdx/ptrWrap helper functions;
  - the CW computation.
- Sub-module ring_span_mask generates the circular span mask combinationally. It takes head index, tail index and a full flag and outputs [0:DEPTH-1]. It is instantiated once for occMask.
- The retire-count run detector is a priority scan inside the top module.

## Test plan

All scenarios use LOG_DEPTH=3, RETIRE_MAX=2.

1. Reset → empty=1, full=0, count=0, occMask=8'b0000_0000, allocReady=1, errDone=0.
2. Eight back-to-back allocs → full=1, count=8, occMask=8'b1111_1111, allocReady=0. A ninth allocReq is ignored: tailIdx=0, no error.
3. Alloc idx 0..3, then done 2, done 1 → retireValid=0. Done 0 → next cycle retireCount=2, retireIdx=0. Cycle after → retireCount=1, retireIdx=2. Then headIdx=3, count=1.
4. Wrap case: drive head to 6 and tail to 2 → occMask=8'b1100_0011, count=4. Complete 6 and 7 → retireCount=2, then headIdx=0.
5. Illegal done on unoccupied idx 5, and a repeated done on an already-done entry → errDone pulses one cycle each; doneMask is unchanged.
6. Full window, head done, allocReq held → that cycle retire=1 and the alloc is ignored. Next cycle allocReady=1, count=7. Then assert rst mid-stream → all outputs return to their reset values on the next cycle.
